// File: rtl/rand_dispatch_pkg.sv
// Shared definitions for the random dispatcher: FSM state codes, LFSR geometry
// and the mask-smear helper used for bounded draws.
package rand_dispatch_pkg;

  localparam int LFSR_W = 12;
  localparam int TAP_A  = 6;
  localparam int TAP_B  = 4;
  localparam int TAP_C  = 1;
  localparam int TAP_D  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Sets every bit below the highest set bit, giving the smallest all-ones mask covering x.
  function automatic logic [LFSR_W-1:0] smear_mask(input logic [LFSR_W-1:0] x);
    logic [LFSR_W-1:0] m;
    m = x;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    return m;
  endfunction

endpackage

// File: rtl/rand_dispatch_lfsr12_step.sv
// Combinational next-state of the 12-bit LFSR, with the all-zero and all-ones
// states rerouted so the register can never lock up.
module lfsr12_step
  import rand_dispatch_pkg::*;
(
  input  logic [LFSR_W-1:0] s_i,
  output logic [LFSR_W-1:0] next_o
);

  logic [LFSR_W-1:0] t;

  assign t      = {s_i[TAP_A] ^ s_i[TAP_B] ^ s_i[TAP_C] ^ s_i[TAP_D], s_i[LFSR_W-1:1]};
  assign next_o = (s_i == '0) ? '1 : ((t == '1) ? '0 : t);

endmodule

// File: rtl/rand_dispatch.sv
// Round-robin dispatcher sharing one LFSR among N_REQ requesters; each grant
// yields one value in [0,limit) by mask-and-reject with a bounded retry count.
module rand_dispatch
  import rand_dispatch_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DRAW_STEPS = 4,
  parameter int MAX_RETRY  = 3,
  parameter bit FREE_RUN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LFSR_W-1:0]     seed,
  input  logic                  reseed,
  input  logic [N_REQ-1:0]      req,
  input  logic [12*N_REQ-1:0]   limit,
  output logic [N_REQ-1:0]      ack,
  output logic [LFSR_W-1:0]     rand_out,
  output logic [2:0]            rand_id,
  output logic                  busy
);

  localparam logic [3:0] STEP_LAST = 4'(DRAW_STEPS - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_e              state_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [LFSR_W-1:0]   lfsr_d;
  logic [2:0]          rr_ptr_q;
  logic [2:0]          rr_ptr_d;
  logic [2:0]          idx_q;
  logic [LFSR_W-1:0]   lim_q;
  logic [3:0]          step_q;
  logic [3:0]          retry_q;
  logic [N_REQ-1:0]    ack_q;
  logic [LFSR_W-1:0]   rand_out_q;
  logic [2:0]          rand_id_q;
  logic                busy_q;

  logic [N_REQ-1:0]    rot;
  logic [3:0]          pos;
  logic                grant_valid;
  logic [2:0]          grant_idx;
  logic [LFSR_W-1:0]   grant_lim;
  logic [N_REQ-1:0]    idx_onehot;
  logic                req_held;
  logic [LFSR_W-1:0]   mask;
  logic [LFSR_W-1:0]   cand;
  logic [LFSR_W-1:0]   result;
  logic                reject;

  lfsr12_step u_step (
    .s_i    (lfsr_q),
    .next_o (lfsr_d)
  );

  // Rotate requests so bit 0 is rr_ptr; scanning downward leaves the nearest one granted.
  always_comb begin
    rot         = N_REQ'({req, req} >> rr_ptr_q);
    pos         = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_valid = 1'b1;
        pos         = {1'b0, rr_ptr_q} + 4'(k);
        grant_idx   = (pos >= 4'(N_REQ)) ? 3'(pos - 4'(N_REQ)) : 3'(pos);
      end
    end
  end

  assign grant_lim  = 12'(limit >> (12 * grant_idx));
  assign idx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
  assign req_held   = |(req & idx_onehot);
  assign rr_ptr_d   = (idx_q == 3'(N_REQ - 1)) ? 3'd0 : idx_q + 3'd1;

  // A rejected candidate minus lim is always below lim because mask < 2*lim.
  always_comb begin
    mask   = smear_mask(lim_q - 12'd1);
    cand   = lfsr_q & mask;
    result = cand;
    reject = 1'b0;
    if (lim_q == '0) begin
      result = lfsr_q;
    end else if (cand >= lim_q) begin
      reject = 1'b1;
      result = cand - lim_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= seed;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      lim_q      <= '0;
      step_q     <= '0;
      retry_q    <= '0;
      ack_q      <= '0;
      rand_out_q <= '0;
      rand_id_q  <= '0;
      busy_q     <= 1'b0;
    end else if (reseed) begin
      state_q <= ST_IDLE;
      lfsr_q  <= seed;
      step_q  <= '0;
      retry_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (FREE_RUN) lfsr_q <= lfsr_d;
          if (grant_valid) begin
            idx_q   <= grant_idx;
            lim_q   <= grant_lim;
            step_q  <= '0;
            retry_q <= '0;
            state_q <= ST_DRAW;
            busy_q  <= 1'b1;
          end
        end
        ST_DRAW: begin
          lfsr_q <= lfsr_d;
          if (step_q == STEP_LAST) state_q <= ST_CHECK;
          else                     step_q  <= step_q + 4'd1;
        end
        ST_CHECK: begin
          if (reject && (retry_q < RETRY_MAX)) begin
            retry_q <= retry_q + 4'd1;
            step_q  <= '0;
            state_q <= ST_DRAW;
          end else begin
            state_q <= ST_DONE;
            if (req_held) begin
              ack_q      <= idx_onehot;
              rand_out_q <= result;
              rand_id_q  <= idx_q;
            end
          end
        end
        ST_DONE: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign rand_out = rand_out_q;
  assign rand_id  = rand_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rand_dispatch.sv
// Directed and table-driven bench for rand_dispatch, plus a modelled random soak.
module tb_rand_dispatch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        reseed;
  logic [11:0] seed;
  logic [3:0]  req_a;
  logic [3:0]  req_b;
  logic [47:0] limit;

  logic [3:0]  ack_w  [3];
  logic [11:0] rout_w [3];
  logic [2:0]  rid_w  [3];
  logic        busy_w [3];

  int checks = 0;
  int errors = 0;

  rand_dispatch #(.N_REQ(4), .DRAW_STEPS(1), .MAX_RETRY(0), .FREE_RUN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .seed(seed), .reseed(reseed), .req(req_a), .limit(limit),
    .ack(ack_w[0]), .rand_out(rout_w[0]), .rand_id(rid_w[0]), .busy(busy_w[0])
  );

  rand_dispatch #(.N_REQ(4), .DRAW_STEPS(1), .MAX_RETRY(1), .FREE_RUN(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .seed(seed), .reseed(reseed), .req(req_b), .limit(limit),
    .ack(ack_w[1]), .rand_out(rout_w[1]), .rand_id(rid_w[1]), .busy(busy_w[1])
  );

  rand_dispatch #(.N_REQ(4), .DRAW_STEPS(4), .MAX_RETRY(3), .FREE_RUN(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .seed(seed), .reseed(reseed), .req(req_b), .limit(limit),
    .ack(ack_w[2]), .rand_out(rout_w[2]), .rand_id(rid_w[2]), .busy(busy_w[2])
  );

  typedef struct {
    logic [11:0] seed;
    int          id;
    logic [11:0] lim;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [11:0] ref_step(input logic [11:0] s);
    logic [11:0] t;
    if (s == 12'h000) return 12'hfff;
    t = {s[6] ^ s[4] ^ s[1] ^ s[0], s[11:1]};
    return (t == 12'hfff) ? 12'h000 : t;
  endfunction

  function automatic logic [11:0] ref_mask(input logic [11:0] x);
    logic [11:0] m;
    logic        found;
    m = 12'h000;
    found = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      if (!found && x[i]) begin
        m = 12'hfff >> (11 - i);
        found = 1'b1;
      end
    end
    return m;
  endfunction

  // Single-attempt result (no retries available).
  function automatic logic [11:0] ref_result(input logic [11:0] l, input logic [11:0] lim);
    logic [11:0] c;
    if (lim == 12'h000) return l;
    c = l & ref_mask(lim - 12'd1);
    if (c < lim) return c;
    return c - lim;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [11:0] s);
    seed   = s;
    rst    = 1'b1;
    reseed = 1'b0;
    req_a  = '0;
    req_b  = '0;
    limit  = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // n counts negedges from the first sample after the request is driven.
  task automatic wait_ack(input int d, input int maxc, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (ack_w[d] != 4'b0000) begin
        lat = n;
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    bit          got;
    int          nack;
    int          id;
    int          sel;
    logic [11:0] m;
    logic [11:0] lim;
    logic [11:0] exp;

    vecs[0]  = '{12'h001, 0, 12'h000, 12'h800};
    vecs[1]  = '{12'hffe, 1, 12'h000, 12'h000};
    vecs[2]  = '{12'h000, 2, 12'h000, 12'hfff};
    vecs[3]  = '{12'hfff, 3, 12'h000, 12'h7ff};
    vecs[4]  = '{12'h00e, 2, 12'h005, 12'h002};
    vecs[5]  = '{12'h001, 1, 12'h001, 12'h000};
    vecs[6]  = '{12'hfff, 0, 12'h800, 12'h7ff};
    vecs[7]  = '{12'h00e, 3, 12'h008, 12'h007};
    vecs[8]  = '{12'h00e, 1, 12'h807, 12'h000};
    vecs[9]  = '{12'h00e, 0, 12'h808, 12'h807};
    vecs[10] = '{12'h001, 2, 12'hfff, 12'h800};
    vecs[11] = '{12'h00e, 3, 12'h006, 12'h001};

    do_reset(12'h001);
    @(negedge clk);
    chk("reset_ack", 32'(ack_w[0]), 32'h0);
    chk("reset_rand_out", 32'(rout_w[0]), 32'h0);
    chk("reset_rand_id", 32'(rid_w[0]), 32'h0);
    chk("reset_busy", 32'(busy_w[0]), 32'h0);

    // Table of single draws on the DRAW_STEPS=1, MAX_RETRY=0 instance.
    for (int v = 0; v < 12; v++) begin
      do_reset(vecs[v].seed);
      limit[12*vecs[v].id +: 12] = vecs[v].lim;
      req_a = 4'b0001 << vecs[v].id;
      wait_ack(0, 10, lat, got);
      chk($sformatf("vec%0d_got_ack", v), 32'(got), 32'h1);
      if (got) begin
        chk($sformatf("vec%0d_ack", v), 32'(ack_w[0]), 32'(4'b0001 << vecs[v].id));
        chk($sformatf("vec%0d_rand_out", v), 32'(rout_w[0]), 32'(vecs[v].exp));
        chk($sformatf("vec%0d_rand_id", v), 32'(rid_w[0]), 32'(vecs[v].id));
        chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd3);
      end
      $display("vec %0d seed=%03h id=%0d lim=%03h -> rand_out=%03h lat=%0d",
               v, vecs[v].seed, vecs[v].id, vecs[v].lim, rout_w[0], lat);
      @(posedge clk);
      #1 req_a = '0;
    end

    // Fairness: all four requesting continuously.
    do_reset(12'h001);
    m = 12'h001;
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(0, 10, lat, got);
      m = ref_step(m);
      chk($sformatf("rr%0d_got_ack", k), 32'(got), 32'h1);
      chk($sformatf("rr%0d_ack", k), 32'(ack_w[0]), 32'(4'b0001 << (k % 4)));
      chk($sformatf("rr%0d_rand_id", k), 32'(rid_w[0]), 32'(k % 4));
      chk($sformatf("rr%0d_rand_out", k), 32'(rout_w[0]), 32'(m));
      chk($sformatf("rr%0d_latency", k), 32'(lat), 32'd3);
      $display("rr %0d ack=%b id=%0d rand_out=%03h", k, ack_w[0], rid_w[0], rout_w[0]);
    end
    @(posedge clk);
    #1 req_a = '0;

    // Reseed while the draw is in DRAW: aborted, then re-granted from the new seed.
    do_reset(12'h001);
    req_a = 4'b0001;
    @(posedge clk);
    #1 seed = 12'h00e;
    reseed = 1'b1;
    @(posedge clk);
    #1 reseed = 1'b0;
    @(negedge clk);
    chk("reseed_idle_busy", 32'(busy_w[0]), 32'h0);
    chk("reseed_idle_ack", 32'(ack_w[0]), 32'h0);
    wait_ack(0, 10, lat, got);
    chk("reseed_got_ack", 32'(got), 32'h1);
    chk("reseed_rand_out", 32'(rout_w[0]), 32'h807);
    chk("reseed_latency", 32'(lat), 32'd2);
    $display("reseed draw rand_out=%03h lat=%0d", rout_w[0], lat);

    // One more draw for requester 3, then reset in the middle of CHECK.
    @(posedge clk);
    #1 req_a = 4'b1000;
    wait_ack(0, 10, lat, got);
    chk("pre_rst_rand_id", 32'(rid_w[0]), 32'h3);
    chk("pre_rst_rand_out", 32'(rout_w[0]), 32'h403);
    @(posedge clk);
    #1 req_a = 4'b0100;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_check_ack", 32'(ack_w[0]), 32'h0);
    chk("rst_check_rand_out", 32'(rout_w[0]), 32'h0);
    chk("rst_check_rand_id", 32'(rid_w[0]), 32'h0);
    chk("rst_check_busy", 32'(busy_w[0]), 32'h0);
    $display("rst mid-check ack=%b rand_out=%03h id=%0d busy=%0d",
             ack_w[0], rout_w[0], rid_w[0], busy_w[0]);
    #1 rst = 1'b0;
    req_a = '0;

    // Requester 2 drops during DRAW: no ack, and the pointer still moves past it.
    do_reset(12'h001);
    req_a = 4'b0100;
    @(posedge clk);
    #1 req_a = '0;
    nack = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_w[0] != 4'b0000) nack++;
    end
    chk("drop_no_ack", 32'(nack), 32'h0);
    @(posedge clk);
    #1 req_a = 4'b1111;
    wait_ack(0, 10, lat, got);
    chk("drop_next_ack", 32'(ack_w[0]), 32'h8);
    chk("drop_next_rand_id", 32'(rid_w[0]), 32'h3);
    chk("drop_next_rand_out", 32'(rout_w[0]), 32'h400);
    $display("after drop ack=%b id=%0d rand_out=%03h", ack_w[0], rid_w[0], rout_w[0]);
    @(posedge clk);
    #1 req_a = '0;

    // MAX_RETRY=1: first candidate rejected, second accepted.
    do_reset(12'h00e);
    limit[11:0] = 12'h005;
    req_b = 4'b0001;
    wait_ack(1, 20, lat, got);
    chk("retry_got_ack", 32'(got), 32'h1);
    chk("retry_rand_out", 32'(rout_w[1]), 32'h003);
    chk("retry_latency", 32'(lat), 32'd5);
    $display("retry draw rand_out=%03h lat=%0d", rout_w[1], lat);
    @(posedge clk);
    #1 req_b = '0;

    // DRAW_STEPS=4 latency and step count.
    do_reset(12'h001);
    req_b = 4'b0001;
    wait_ack(2, 20, lat, got);
    chk("steps4_got_ack", 32'(got), 32'h1);
    chk("steps4_rand_out", 32'(rout_w[2]), 32'h100);
    chk("steps4_latency", 32'(lat), 32'd6);
    $display("steps4 draw rand_out=%03h lat=%0d", rout_w[2], lat);
    @(posedge clk);
    #1 req_b = '0;

    // Random soak against the reference model.
    do_reset(12'h3c5);
    m = 12'h3c5;
    for (int i = 0; i < 10000; i++) begin
      id  = $urandom_range(0, 3);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       lim = 12'h000;
        1:       lim = 12'h001;
        2:       lim = 12'($urandom_range(2, 31));
        default: lim = 12'($urandom_range(1, 4095));
      endcase
      limit = '0;
      limit[12*id +: 12] = lim;
      req_a = 4'b0001 << id;
      wait_ack(0, 10, lat, got);
      m   = ref_step(m);
      exp = ref_result(m, lim);
      chk($sformatf("soak%0d_got_ack", i), 32'(got), 32'h1);
      chk($sformatf("soak%0d_rand_out", i), 32'(rout_w[0]), 32'(exp));
      if (lim != 12'h000)
        chk($sformatf("soak%0d_in_range", i), 32'(rout_w[0] < lim), 32'h1);
      if (i % 1000 == 0)
        $display("soak %0d id=%0d lim=%03h rand_out=%03h", i, id, lim, rout_w[0]);
      @(posedge clk);
      #1 req_a = '0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
